boreal_gate_mc: RTL and testbench

Multi-channel, parametrised action commit gate. It arbitrates `NUM_CH` action requesters round-robin and keeps per-channel nonces and rate counters. It enforces allowlist, policy-hash, rate and bounds policy, writes sanitised values to Privileged I/O with an ack timeout, and commits one back-pressured 256-bit ledger entry per request. It sits between the Decision-VM request fabric and Privileged I/O / ledger, and is the only path to either.

---
 rtl/boreal_pkg.sv | 59 +++++
 rtl/boreal_rr_arb.sv | 35 +++
 rtl/boreal_gate_mc.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_boreal_gate_mc.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boreal_pkg.sv
// Shared definitions for the boreal action commit gate.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package boreal_pkg;

    // Action opcodes
    localparam logic [31:0] ACT_NOP   = 32'h0000_0000;
    localparam logic [31:0] ACT_WRITE = 32'h0000_0001;

    // Response / ledger reason codes
    localparam logic [7:0] REASON_OK            = 8'd0;
    localparam logic [7:0] REASON_POLICY_DENIED = 8'd1;
    localparam logic [7:0] REASON_RATE_LIMITED  = 8'd2;
    localparam logic [7:0] REASON_NONCE_ERROR   = 8'd3;
    localparam logic [7:0] REASON_INVALID       = 8'd4;
    localparam logic [7:0] REASON_CLAMPED       = 8'd5;
    localparam logic [7:0] REASON_TIMEOUT       = 8'd6;

    // Privileged I/O window; target t lives at base + 4*t
    localparam logic [31:0] ADDR_PRIV_IO_BASE = 32'h4000_0000;

    // Ledger entry field offsets (LSB positions within the 256-bit entry)
    localparam int LDG_CYCLE_LSB     = 224;
    localparam int LDG_NONCE_LSB     = 192;
    localparam int LDG_OPCODE_LSB    = 160;
    localparam int LDG_TARGET_LSB    = 128;
    localparam int LDG_APPLIED0_LSB  = 96;
    localparam int LDG_REASON_LSB    = 88;
    localparam int LDG_CH_LSB        = 80;
    localparam int LDG_COMMITTED_BIT = 64;
    localparam int LDG_CTX_LSB       = 32;
    localparam int LDG_POLICY_LSB    = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CLAMP,
        ST_COMMIT,
        ST_LEDGER,
        ST_RESPOND
    } gate_state_t;

    // One latched action request
    typedef struct packed {
        logic [31:0] opcode;
        logic [31:0] target;
        logic [31:0] arg0;
        logic [31:0] arg1;
        logic [31:0] context_hash;
        logic [31:0] policy_hash;
        logic [31:0] bounds;
        logic [31:0] nonce;
    } act_req_t;

    function automatic logic [31:0] priv_addr_of(input logic [31:0] target);
        return ADDR_PRIV_IO_BASE + {14'b0, target[15:0], 2'b00};
    endfunction

endpackage

// File: rtl/boreal_rr_arb.sv
// Round-robin one-hot arbiter: first requester at or after ptr wins.
// Latency: purely combinational.
// Backpressure: none; caller gates the grant with its own ready condition.
//
// Ports: req (per-channel request), ptr (search start), grant (one-hot),
//        grant_idx (binary winner), grant_vld (any request present).
module boreal_rr_arb #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_vld
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/boreal_gate_mc.sv
// Multi-channel action commit gate: RR arbitration, policy checks, clamp, priv I/O write, ledger.
// Latency: accept->resp 5 cycles for a full pass; +1 per ack-wait cycle and per ledger stall cycle.
// Backpressure: one request in flight; act_ready only in IDLE; ledger_wr_en held until ledger_ready.
//
// Ports: act_* (flattened per-channel requests, channel i at [32i+31:32i]),
//        resp_* (one-hot pulse + shared payload), allow_mask/rate_*/policy_hash/override_reg (config),
//        nonce_counter (per-channel expected nonce), priv_* (Privileged I/O), ledger_* (ledger sink).
module boreal_gate_mc
    import boreal_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int NUM_TGT = 64,
    parameter int TO_CYC  = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    act_valid,
    output logic [NUM_CH-1:0]    act_ready,
    input  logic [NUM_CH*32-1:0] act_opcode,
    input  logic [NUM_CH*32-1:0] act_target,
    input  logic [NUM_CH*32-1:0] act_arg0,
    input  logic [NUM_CH*32-1:0] act_arg1,
    input  logic [NUM_CH*32-1:0] act_context_hash,
    input  logic [NUM_CH*32-1:0] act_policy_hash,
    input  logic [NUM_CH*32-1:0] act_bounds,
    input  logic [NUM_CH*32-1:0] act_nonce,
    output logic [NUM_CH-1:0]    resp_valid,
    output logic [31:0]          resp_committed,
    output logic [31:0]          resp_reason,
    output logic [31:0]          resp_applied0,
    output logic [31:0]          resp_applied1,
    output logic [31:0]          resp_ledger_idx,
    input  logic [NUM_TGT-1:0]   allow_mask,
    input  logic [31:0]          rate_limit,
    input  logic [31:0]          rate_window,
    input  logic [31:0]          policy_hash,
    input  logic [31:0]          override_reg,
    output logic [NUM_CH*32-1:0] nonce_counter,
    output logic                 priv_req,
    output logic                 priv_wr,
    output logic [31:0]          priv_addr,
    output logic [31:0]          priv_wdata,
    input  logic                 priv_ack,
    output logic                 ledger_wr_en,
    output logic [255:0]         ledger_wr_data,
    input  logic                 ledger_ready,
    input  logic [31:0]          ledger_idx
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TGT_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
    localparam int TO_W  = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    gate_state_t     state_q, state_d;
    act_req_t        req_q, win_req;
    logic [CH_W-1:0] ch_q, rr_ptr_q, nxt_ptr;

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_vld;

    logic [31:0]     applied0_q, applied0_d;
    logic [31:0]     applied1_q, applied1_d;
    logic [7:0]      reason_q, reason_d;
    logic            committed_q, committed_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic [31:0] cycle_ctr_q, stamp_q, rate_timer_q;
    logic [31:0] nonce_q [NUM_CH];
    logic [31:0] rate_q  [NUM_CH];

    logic        rate_inc, win_clr, ledger_accept, is_write;
    logic [31:0] bnd_max, bnd_min;
    logic [255:0] led;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    boreal_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req       (act_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign act_ready = (state_q == ST_IDLE) ? grant : '0;
    assign nxt_ptr   = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;

    always_comb begin
        win_req.opcode       = act_opcode      [32*int'(grant_idx) +: 32];
        win_req.target       = act_target      [32*int'(grant_idx) +: 32];
        win_req.arg0         = act_arg0        [32*int'(grant_idx) +: 32];
        win_req.arg1         = act_arg1        [32*int'(grant_idx) +: 32];
        win_req.context_hash = act_context_hash[32*int'(grant_idx) +: 32];
        win_req.policy_hash  = act_policy_hash [32*int'(grant_idx) +: 32];
        win_req.bounds       = act_bounds      [32*int'(grant_idx) +: 32];
        win_req.nonce        = act_nonce       [32*int'(grant_idx) +: 32];
    end

    assign is_write      = (req_q.opcode == ACT_WRITE);
    assign bnd_max       = {16'b0, req_q.bounds[31:16]};
    assign bnd_min       = {16'b0, req_q.bounds[15:0]};
    assign ledger_accept = (state_q == ST_LEDGER) && ledger_ready;
    // >= rather than == so that lowering rate_window below the running timer clears promptly
    assign win_clr       = (rate_timer_q >= rate_window);

    // ------------------------------------------------------------------
    // FSM next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        applied0_d  = applied0_q;
        applied1_d  = applied1_q;
        reason_d    = reason_q;
        committed_d = committed_q;
        to_cnt_d    = to_cnt_q;
        rate_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                applied0_d  = req_q.arg0;
                applied1_d  = req_q.arg1;
                reason_d    = REASON_OK;
                committed_d = 1'b1;
                to_cnt_d    = '0;
                state_d     = ST_CLAMP;
                if (req_q.opcode == ACT_NOP) begin
                    state_d = ST_LEDGER;
                end else if (req_q.nonce != nonce_q[ch_q]) begin
                    reason_d = REASON_NONCE_ERROR; committed_d = 1'b0; state_d = ST_LEDGER;
                end else if (req_q.policy_hash != policy_hash && override_reg == 32'd0) begin
                    reason_d = REASON_POLICY_DENIED; committed_d = 1'b0; state_d = ST_LEDGER;
                end else if (req_q.target >= 32'(NUM_TGT)) begin
                    reason_d = REASON_INVALID; committed_d = 1'b0; state_d = ST_LEDGER;
                end else if (!allow_mask[req_q.target[TGT_W-1:0]]) begin
                    reason_d = REASON_POLICY_DENIED; committed_d = 1'b0; state_d = ST_LEDGER;
                end else if (rate_q[ch_q] >= rate_limit) begin
                    reason_d = REASON_RATE_LIMITED; committed_d = 1'b0; state_d = ST_LEDGER;
                end
            end
            ST_CLAMP: begin
                state_d = ST_COMMIT;
                // bounds == 0 means "unbounded"
                if (req_q.bounds != 32'd0) begin
                    if (bnd_max < bnd_min) begin
                        reason_d = REASON_INVALID; committed_d = 1'b0; state_d = ST_LEDGER;
                    end else if (applied0_q > bnd_max) begin
                        applied0_d = bnd_max; reason_d = REASON_CLAMPED;
                    end else if (applied0_q < bnd_min) begin
                        applied0_d = bnd_min; reason_d = REASON_CLAMPED;
                    end
                end
            end
            ST_COMMIT: begin
                if (is_write) begin
                    if (priv_ack) begin
                        state_d  = ST_LEDGER;
                        rate_inc = committed_q;
                    end else if (to_cnt_q == TO_LAST) begin
                        // Out of patience: priv_req drops as we leave COMMIT
                        reason_d = REASON_TIMEOUT; committed_d = 1'b0; state_d = ST_LEDGER;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end else begin
                    state_d  = ST_LEDGER;
                    rate_inc = committed_q;
                end
            end
            ST_LEDGER: begin
                if (ledger_ready) state_d = ST_RESPOND;
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            ch_q        <= '0;
            rr_ptr_q    <= '0;
            applied0_q  <= '0;
            applied1_q  <= '0;
            reason_q    <= '0;
            committed_q <= 1'b0;
            to_cnt_q    <= '0;
            cycle_ctr_q <= '0;
            stamp_q     <= '0;
        end else begin
            state_q     <= state_d;
            applied0_q  <= applied0_d;
            applied1_q  <= applied1_d;
            reason_q    <= reason_d;
            committed_q <= committed_d;
            to_cnt_q    <= to_cnt_d;
            cycle_ctr_q <= cycle_ctr_q + 32'd1;
            if (state_q == ST_IDLE && grant_vld) begin
                req_q    <= win_req;
                ch_q     <= grant_idx;
                rr_ptr_q <= nxt_ptr;
            end
            // Stamp once on LEDGER entry so the entry stays stable under back-pressure
            if (state_d == ST_LEDGER && state_q != ST_LEDGER) stamp_q <= cycle_ctr_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel nonces and rate counters, global rate window
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_timer_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                nonce_q[i] <= '0;
                rate_q[i]  <= '0;
            end
        end else begin
            rate_timer_q <= win_clr ? 32'd0 : rate_timer_q + 32'd1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (win_clr) begin
                    rate_q[i] <= (rate_inc && ch_q == CH_W'(i)) ? 32'd1 : 32'd0;
                end else if (rate_inc && ch_q == CH_W'(i) && rate_q[i] != '1) begin
                    rate_q[i] <= rate_q[i] + 32'd1;
                end
                if (ledger_accept && ch_q == CH_W'(i)) nonce_q[i] <= nonce_q[i] + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign priv_req   = (state_q == ST_COMMIT) && is_write && committed_q;
    assign priv_wr    = priv_req;
    assign priv_addr  = priv_req ? priv_addr_of(req_q.target) : 32'd0;
    assign priv_wdata = priv_req ? applied0_q : 32'd0;

    always_comb begin
        led = '0;
        led[LDG_CYCLE_LSB    +: 32] = stamp_q;
        led[LDG_NONCE_LSB    +: 32] = req_q.nonce;
        led[LDG_OPCODE_LSB   +: 32] = req_q.opcode;
        led[LDG_TARGET_LSB   +: 32] = req_q.target;
        led[LDG_APPLIED0_LSB +: 32] = applied0_q;
        led[LDG_REASON_LSB   +: 8]  = reason_q;
        led[LDG_CH_LSB       +: 8]  = 8'(ch_q);
        led[LDG_COMMITTED_BIT]      = committed_q;
        led[LDG_CTX_LSB      +: 32] = req_q.context_hash;
        led[LDG_POLICY_LSB   +: 32] = req_q.policy_hash;
    end

    assign ledger_wr_en   = (state_q == ST_LEDGER);
    assign ledger_wr_data = ledger_wr_en ? led : '0;

    always_comb begin
        resp_valid = '0;
        if (state_q == ST_RESPOND) resp_valid[ch_q] = 1'b1;
    end

    assign resp_committed  = (state_q == ST_RESPOND) ? {31'b0, committed_q} : 32'd0;
    assign resp_reason     = (state_q == ST_RESPOND) ? {24'b0, reason_q}    : 32'd0;
    assign resp_applied0   = (state_q == ST_RESPOND) ? applied0_q           : 32'd0;
    assign resp_applied1   = (state_q == ST_RESPOND) ? applied1_q           : 32'd0;
    assign resp_ledger_idx = (state_q == ST_RESPOND) ? ledger_idx           : 32'd0;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_nonce_out
            assign nonce_counter[32*g +: 32] = nonce_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_boreal_gate_mc.sv
// Directed bench for boreal_gate_mc: arbitration order, policy checks, clamp, timeout, rate window.
// Latency: transaction latency measured in cycles from accept edge to resp_valid.
// Backpressure: drives priv_ack and ledger_ready per transaction to exercise stalls.
module tb_boreal_gate_mc;

    localparam int NCH = 4;
    localparam logic [31:0] OP_NOP = 32'h0, OP_WR = 32'h1, OP_RD = 32'h2;
    localparam logic [31:0] PHASH  = 32'hCAFE_0001;
    localparam int R_OK = 0, R_POL = 1, R_RATE = 2, R_NONCE = 3, R_INV = 4, R_CLAMP = 5, R_TO = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NCH-1:0]     act_valid = '0;
    logic [NCH-1:0]     act_ready;
    logic [NCH*32-1:0]  act_opcode = '0, act_target = '0, act_arg0 = '0, act_arg1 = '0;
    logic [NCH*32-1:0]  act_context_hash = '0, act_policy_hash = '0, act_bounds = '0, act_nonce = '0;
    logic [NCH-1:0]     resp_valid;
    logic [31:0]        resp_committed, resp_reason, resp_applied0, resp_applied1, resp_ledger_idx;
    logic [63:0]        allow_mask = 64'h0000_0000_0000_0020;
    logic [31:0]        rate_limit = 32'hFFFF_FFFF, rate_window = 32'hFFFF_FFFF;
    logic [31:0]        policy_hash = PHASH, override_reg = 32'd0;
    logic [NCH*32-1:0]  nonce_counter;
    logic               priv_req, priv_wr, priv_ack = 1'b0;
    logic [31:0]        priv_addr, priv_wdata;
    logic               ledger_wr_en, ledger_ready = 1'b0;
    logic [255:0]       ledger_wr_data;
    logic [31:0]        ledger_idx = 32'h0000_0077;

    always #5 clk = ~clk;

    boreal_gate_mc #(.NUM_CH(NCH), .NUM_TGT(64), .TO_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .act_valid(act_valid), .act_ready(act_ready),
        .act_opcode(act_opcode), .act_target(act_target), .act_arg0(act_arg0), .act_arg1(act_arg1),
        .act_context_hash(act_context_hash), .act_policy_hash(act_policy_hash),
        .act_bounds(act_bounds), .act_nonce(act_nonce),
        .resp_valid(resp_valid), .resp_committed(resp_committed), .resp_reason(resp_reason),
        .resp_applied0(resp_applied0), .resp_applied1(resp_applied1), .resp_ledger_idx(resp_ledger_idx),
        .allow_mask(allow_mask), .rate_limit(rate_limit), .rate_window(rate_window),
        .policy_hash(policy_hash), .override_reg(override_reg), .nonce_counter(nonce_counter),
        .priv_req(priv_req), .priv_wr(priv_wr), .priv_addr(priv_addr), .priv_wdata(priv_wdata),
        .priv_ack(priv_ack), .ledger_wr_en(ledger_wr_en), .ledger_wr_data(ledger_wr_data),
        .ledger_ready(ledger_ready), .ledger_idx(ledger_idx)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Captured results of the most recent transaction
    int           lat, priv_cnt, led_cnt;
    bit           got_resp, led_stable;
    logic [31:0]  cap_addr, cap_wdata, cap_comm, cap_reason, cap_app0, cap_app1, cap_lidx;
    logic [NCH-1:0] cap_rv;
    logic [255:0] led_first;

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] op, input logic [31:0] tgt,
                          input logic [31:0] a0, input logic [31:0] bnd,
                          input logic [31:0] nonce, input logic [31:0] pol);
        act_opcode[32*ch +: 32]       = op;
        act_target[32*ch +: 32]       = tgt;
        act_arg0[32*ch +: 32]         = a0;
        act_arg1[32*ch +: 32]         = 32'hA1A1_0000 + 32'(ch);
        act_bounds[32*ch +: 32]       = bnd;
        act_nonce[32*ch +: 32]        = nonce;
        act_policy_hash[32*ch +: 32]  = pol;
        act_context_hash[32*ch +: 32] = 32'hC0C0_0000 + 32'(ch);
    endtask

    // Issue one request on ch and follow it to its response.
    // ack_at: assert priv_ack on the n-th priv_req cycle (0 = never).
    // lr_low: hold ledger_ready low for this many ledger_wr_en cycles.
    task automatic run_txn(input int ch, input logic [31:0] op, input logic [31:0] tgt,
                           input logic [31:0] a0, input logic [31:0] bnd,
                           input logic [31:0] nonce, input logic [31:0] pol,
                           input int ack_at, input int lr_low);
        int n;
        set_ch(ch, op, tgt, a0, bnd, nonce, pol);
        act_valid[ch] = 1'b1;
        n = 0;
        #1;
        while (!act_ready[ch] && n < 50) begin
            @(negedge clk); #1; n++;
        end
        got_resp = 0; priv_cnt = 0; led_cnt = 0; led_stable = 1; lat = 0;
        cap_addr = '0; cap_wdata = '0; led_first = '0;
        if (!act_ready[ch]) begin
            act_valid[ch] = 1'b0;
            chk("grant_wait", 0, 1);
            return;
        end
        @(posedge clk);
        for (int c = 1; c <= 200 && !got_resp; c++) begin
            @(negedge clk);
            act_valid[ch] = 1'b0;
            if (priv_req) begin
                priv_cnt++;
                cap_addr  = priv_addr;
                cap_wdata = priv_wdata;
                priv_ack  = (ack_at > 0 && priv_cnt >= ack_at);
            end else begin
                priv_ack = 1'b0;
            end
            if (ledger_wr_en) begin
                if (led_cnt == 0) led_first = ledger_wr_data;
                else if (ledger_wr_data !== led_first) led_stable = 0;
                led_cnt++;
                ledger_ready = (led_cnt > lr_low);
            end else begin
                ledger_ready = 1'b0;
            end
            if (resp_valid != '0) begin
                got_resp   = 1;
                lat        = c;
                cap_rv     = resp_valid;
                cap_comm   = resp_committed;
                cap_reason = resp_reason;
                cap_app0   = resp_applied0;
                cap_app1   = resp_applied1;
                cap_lidx   = resp_ledger_idx;
            end
        end
        priv_ack     = 1'b0;
        ledger_ready = 1'b0;
        if (!got_resp) chk("resp_wait", 0, 1);
    endtask

    function automatic int oh2idx(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int order [4];
        int nresp;
        int seen;

        reset_dut();

        // ---- Reset state ----
        chk("rst_act_ready", act_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_priv_req", priv_req, 0);
        chk("rst_ledger_wr_en", ledger_wr_en, 0);
        chk("rst_ledger_data_nz", 64'(ledger_wr_data != '0), 0);
        chk("rst_nonce_all", nonce_counter[63:0] | nonce_counter[127:64], 0);
        act_valid = 4'b0100;
        #1;
        chk("rst_rr_from_ptr0", act_ready, 4'b0100);
        act_valid = 4'b0000;

        // ---- Round-robin with NOPs on ch 0, 2, 3 ----
        for (int i = 0; i < NCH; i++) set_ch(i, OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, PHASH);
        ledger_ready = 1'b1;
        act_valid = 4'b1101;
        nresp = 0;
        for (int c = 0; c < 100 && nresp < 4; c++) begin
            @(negedge clk);
            if (resp_valid != '0) begin
                order[nresp] = oh2idx(resp_valid);
                nresp++;
                if (nresp == 4) act_valid = '0;
            end
        end
        act_valid = '0;
        ledger_ready = 1'b0;
        chk("rr_count", nresp, 4);
        chk("rr_grant0", order[0], 0);
        chk("rr_grant1", order[1], 2);
        chk("rr_grant2", order[2], 3);
        chk("rr_grant3", order[3], 0);
        chk("rr_nonce_ch0", nonce_counter[31:0], 2);
        chk("rr_nonce_ch1", nonce_counter[63:32], 0);
        chk("rr_nonce_ch2", nonce_counter[95:64], 1);
        chk("rr_nonce_ch3", nonce_counter[127:96], 1);

        // ---- Clamp on write: ch1, target 5, arg0 0x500, max 0x400 min 0x10 ----
        run_txn(1, OP_WR, 32'd5, 32'h500, 32'h0400_0010, 32'd0, PHASH, 1, 0);
        chk("clamp_priv_cnt", priv_cnt, 1);
        chk("clamp_priv_wdata", cap_wdata, 32'h400);
        chk("clamp_priv_addr", cap_addr, 32'h4000_0014);
        chk("clamp_resp_ch", cap_rv, 4'b0010);
        chk("clamp_reason", cap_reason, R_CLAMP);
        chk("clamp_committed", cap_comm, 1);
        chk("clamp_applied0", cap_app0, 32'h400);
        chk("clamp_applied1", cap_app1, 32'hA1A1_0001);
        chk("clamp_ledger_idx", cap_lidx, 32'h77);
        chk("clamp_latency", lat, 5);
        chk("clamp_led_reason", led_first[95:88], R_CLAMP);
        chk("clamp_led_ch", led_first[87:80], 1);
        chk("clamp_led_committed", led_first[64], 1);
        chk("clamp_led_applied0", led_first[127:96], 32'h400);
        chk("clamp_led_opcode", led_first[191:160], OP_WR);
        chk("clamp_led_policy", led_first[31:0], PHASH);
        chk("clamp_nonce_ch1", nonce_counter[63:32], 1);

        // ---- Invalid bounds pair (max < min) ----
        run_txn(1, OP_WR, 32'd5, 32'h500, 32'h0010_0400, 32'd1, PHASH, 1, 0);
        chk("badbnd_priv_cnt", priv_cnt, 0);
        chk("badbnd_reason", cap_reason, R_INV);
        chk("badbnd_committed", cap_comm, 0);
        chk("badbnd_nonce_ch1", nonce_counter[63:32], 2);

        // ---- CHECK rejects on ch3 (expected nonce 1) ----
        run_txn(3, OP_WR, 32'd5, 32'h1, 32'd0, 32'd5, PHASH, 1, 0);
        chk("nonce_err_reason", cap_reason, R_NONCE);
        chk("nonce_err_committed", cap_comm, 0);
        run_txn(3, OP_WR, 32'd5, 32'h1, 32'd0, 32'd2, 32'h0000_0BAD, 1, 0);
        chk("pol_hash_reason", cap_reason, R_POL);
        run_txn(3, OP_WR, 32'd70, 32'h1, 32'd0, 32'd3, PHASH, 1, 0);
        chk("tgt_range_reason", cap_reason, R_INV);
        run_txn(3, OP_WR, 32'd6, 32'h1, 32'd0, 32'd4, PHASH, 1, 0);
        chk("allow_reason", cap_reason, R_POL);
        chk("allow_priv_cnt", priv_cnt, 0);
        chk("rej_nonce_ch3", nonce_counter[127:96], 5);

        // ---- Ack timeout on ch2 (expected nonce 1) ----
        run_txn(2, OP_WR, 32'd5, 32'h9, 32'd0, 32'd1, PHASH, 0, 0);
        chk("to_priv_cnt", priv_cnt, 8);
        chk("to_reason", cap_reason, R_TO);
        chk("to_committed", cap_comm, 0);
        chk("to_latency", lat, 12);
        // A timed-out write must not have consumed rate budget
        rate_limit = 32'd1;
        run_txn(2, OP_WR, 32'd5, 32'h9, 32'd0, 32'd2, PHASH, 1, 0);
        chk("to_rate_reason", cap_reason, R_OK);
        chk("to_rate_committed", cap_comm, 1);
        chk("to_nonce_ch2", nonce_counter[95:64], 3);
        rate_limit = 32'hFFFF_FFFF;

        // ---- Rate limit and window clear ----
        reset_dut();
        rate_limit  = 32'd2;
        rate_window = 32'd100;
        run_txn(0, OP_WR, 32'd5, 32'h1, 32'd0, 32'd0, PHASH, 1, 0);
        chk("rate_w1_reason", cap_reason, R_OK);
        run_txn(0, OP_WR, 32'd5, 32'h1, 32'd0, 32'd1, PHASH, 1, 0);
        chk("rate_w2_reason", cap_reason, R_OK);
        run_txn(0, OP_WR, 32'd5, 32'h1, 32'd0, 32'd2, PHASH, 1, 0);
        chk("rate_w3_reason", cap_reason, R_RATE);
        chk("rate_w3_committed", cap_comm, 0);
        chk("rate_w3_priv_cnt", priv_cnt, 0);
        run_txn(1, OP_WR, 32'd5, 32'h1, 32'd0, 32'd0, PHASH, 1, 0);
        chk("rate_ch1_reason", cap_reason, R_OK);
        chk("rate_ch1_committed", cap_comm, 1);
        repeat (110) @(negedge clk);
        run_txn(0, OP_WR, 32'd5, 32'h1, 32'd0, 32'd3, PHASH, 1, 0);
        chk("rate_after_clr_reason", cap_reason, R_OK);
        chk("rate_after_clr_committed", cap_comm, 1);
        rate_limit  = 32'hFFFF_FFFF;
        rate_window = 32'hFFFF_FFFF;

        // ---- Ledger back-pressure ----
        run_txn(3, OP_RD, 32'd5, 32'h1, 32'd0, 32'd0, PHASH, 0, 0);
        chk("rd_latency", lat, 5);
        chk("rd_priv_cnt", priv_cnt, 0);
        run_txn(2, OP_RD, 32'd5, 32'h1, 32'd0, 32'd0, PHASH, 0, 10);
        chk("bp_latency", lat, 15);
        chk("bp_led_cycles", led_cnt, 11);
        chk("bp_led_stable", led_stable, 1);
        chk("bp_reason", cap_reason, R_OK);
        chk("bp_committed", cap_comm, 1);

        // ---- Reset asserted during COMMIT ----
        reset_dut();
        set_ch(0, OP_WR, 32'd5, 32'h1, 32'd0, 32'd0, PHASH);
        act_valid[0] = 1'b1;
        #1;
        chk("rstmid_grant", act_ready, 4'b0001);
        @(posedge clk);
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            act_valid = '0;
            if (ledger_wr_en) seen++;
        end
        chk("rstmid_in_commit", priv_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_priv_drop", priv_req, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ledger_wr_en) seen++;
        end
        chk("rstmid_no_ledger", seen, 0);
        chk("rstmid_nonce_ch0", nonce_counter[31:0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
